axi_stream_video_switch: RTL



---
 rtl/axi_stream_video_switch.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axi_stream_video_switch.sv
// N-input AXI4-Stream video switch; source changes only on frame boundaries.
// Optional: define VIDEO_SWITCH_FLUSH_EN so unselected channels are drained instead of stalled.
module axi_stream_video_switch #(
  parameter int unsigned DW = 24,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N),
  parameter int unsigned CW = 16
) (
  input  logic            axi_clk_i,
  input  logic            axi_rstn_i,
  input  logic [N*DW-1:0] s_tdata_i,
  input  logic [N-1:0]    s_tvalid_i,
  input  logic [N-1:0]    s_tuser_i,
  input  logic [N-1:0]    s_tlast_i,
  output logic [N-1:0]    s_tready_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic            m_tvalid_o,
  output logic            m_tuser_o,
  output logic            m_tlast_o,
  input  logic            m_tready_i,
  input  logic [SW-1:0]   sel_i,
  output logic [SW-1:0]   active_sel_o,
  output logic            pending_o,
  output logic            locked_o,
  output logic [CW-1:0]   frame_cnt_o,
  output logic [CW-1:0]   drop_cnt_o
);

`ifdef VIDEO_SWITCH_FLUSH_EN
  localparam logic FLUSH = 1'b1;
`else
  localparam logic FLUSH = 1'b0;
`endif

  typedef enum logic {SYNC, LOCK} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [DW-1:0] cur_data_c;
  logic          cur_valid_c, cur_user_c, cur_last_c;
  logic          adv_c, sel_ok_c, pend_c;
  logic          ready_cur_c, take_c, sof_take_c, drop_c;
  logic [N-1:0]  ready_c;

  // Out-of-range selectors only exist when N is not a power of two
  if ((1 << SW) == N) begin : g_sel_pow2
    assign sel_ok_c = 1'b1;
  end else begin : g_sel_range
    assign sel_ok_c = (32'(sel_i) < N);
  end

  assign adv_c  = m_tready_i | ~m_tvalid_o;
  assign pend_c = (sel_i != cur_q) & sel_ok_c;

  // Bound-channel input mux
  always_comb begin
    cur_data_c  = '0;
    cur_valid_c = 1'b0;
    cur_user_c  = 1'b0;
    cur_last_c  = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (SW'(k) == cur_q) begin
        cur_data_c  = s_tdata_i[k*DW +: DW];
        cur_valid_c = s_tvalid_i[k];
        cur_user_c  = s_tuser_i[k];
        cur_last_c  = s_tlast_i[k];
      end
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      state_q <= SYNC;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  // Next state plus per-cycle accept/drop decisions; ready never looks at tvalid
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    ready_cur_c = 1'b0;
    take_c      = 1'b0;
    sof_take_c  = 1'b0;
    drop_c      = 1'b0;
    case (state_q)
      SYNC: begin
        ready_cur_c = ~cur_user_c | (adv_c & ~pend_c);
        if (pend_c) cur_d = sel_i;
        if (cur_valid_c) begin
          if (!cur_user_c) begin
            drop_c = 1'b1;
          end else if (adv_c && !pend_c) begin
            take_c     = 1'b1;
            sof_take_c = 1'b1;
            state_d    = LOCK;
          end
        end
      end
      LOCK: begin
        ready_cur_c = adv_c & ~(cur_user_c & pend_c);
        if (cur_valid_c && cur_user_c && pend_c) begin
          cur_d   = sel_i;
          state_d = SYNC;
        end else if (cur_valid_c && adv_c) begin
          take_c     = 1'b1;
          sof_take_c = cur_user_c;
        end
      end
    endcase
  end

  always_comb begin
    ready_c = '0;
    for (int k = 0; k < int'(N); k++) begin
      ready_c[k] = (SW'(k) == cur_q) ? ready_cur_c : FLUSH;
    end
  end

  assign s_tready_o   = axi_rstn_i ? ready_c : '0;
  assign pending_o    = axi_rstn_i & pend_c;
  assign locked_o     = (state_q == LOCK);
  assign active_sel_o = cur_q;

  // Output pipeline register and status counters
  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      m_tdata_o   <= '0;
      m_tvalid_o  <= 1'b0;
      m_tuser_o   <= 1'b0;
      m_tlast_o   <= 1'b0;
      frame_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (take_c) begin
        m_tdata_o  <= cur_data_c;
        m_tvalid_o <= 1'b1;
        m_tuser_o  <= cur_user_c;
        m_tlast_o  <= cur_last_c;
      end else if (adv_c) begin
        m_tvalid_o <= 1'b0;
      end
      if (sof_take_c) frame_cnt_o <= frame_cnt_o + CW'(1);
      if (drop_c)     drop_cnt_o  <= drop_cnt_o + CW'(1);
    end
  end

endmodule
